bit_stream_operand_serializer: RTL

Upstream feeder for the bit-serial adder FSM. Accepts two WIDTH-bit operands per frame over a valid/ready handshake and streams them LSB-first as paired single-bit streams `a_bit`/`b_bit`, one bit per clock. The adder samples these on its `A`/`B` inputs every cycle. Each frame ends with zero guard bits, so the adder's carry-out is emitted and its carry state returns to 0 before the next frame. The adder has no reset or enable, so every idle cycle must present 0/0 on its inputs.

---
 rtl/bit_stream_operand_serializer.sv | 63 ++++++
 1 files changed

// File: rtl/bit_stream_operand_serializer.sv
// bit_stream_operand_serializer: latches operand pairs and streams them LSB-first to a bit-serial adder,
// padding each frame with 0/0 guard bits so the adder's carry drains between frames.
module bit_stream_operand_serializer #(
    parameter int WIDTH      = 8,
    parameter int GUARD_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    output logic             bit_first,
    output logic             bit_last
);
    localparam int FRAME = WIDTH + GUARD_BITS;
    localparam int CW    = $clog2(FRAME);
    localparam logic [1:0] DRAIN = 2'd0, IDLE = 2'd1, SHIFT = 2'd2, GUARD = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa, sb;
    logic             accept, shift_end, guard_end;

    assign shift_end = cnt == CW'(WIDTH - 1);
    assign guard_end = cnt == CW'(FRAME - 1);
    assign accept    = in_valid && in_ready;

    // outputs are decoded from registers only; rst forces the adder inputs to 0/0 immediately
    assign in_ready  = !rst && (state == IDLE || (state == GUARD && guard_end));
    assign a_bit     = !rst && state == SHIFT && sa[0];
    assign b_bit     = !rst && state == SHIFT && sb[0];
    assign bit_valid = !rst && state[1];
    assign bit_first = !rst && state == SHIFT && cnt == '0;
    assign bit_last  = !rst && state == GUARD && guard_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DRAIN;
            cnt   <= '0;
            sa    <= '0;
            sb    <= '0;
        end else if (accept) begin
            state <= SHIFT;
            cnt   <= '0;
            sa    <= in_a;
            sb    <= in_b;
        end else if (state == SHIFT) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            cnt   <= cnt + 1'b1;
            state <= shift_end ? GUARD : SHIFT;
        end else if (state == GUARD) begin
            cnt   <= cnt + 1'b1;
            state <= guard_end ? IDLE : GUARD;
        end else if (state == DRAIN) begin
            state <= IDLE;
        end
    end
endmodule
